// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
//   Serial receive engine for the memory-mapped UART. It synchronises the rxd
//   pin, deserialises 8N1 frames at a programmable bit period and buffers the
//   received bytes in a small first-word-fall-through FIFO that the register
//   slave pops through its data register.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   rxd        asynchronous serial input, idle high
//   div[15:0]  bit period minus one in clk cycles (values below 3 act as 3)
//   rd_en      pop the FIFO head this cycle
//   rd_data    FIFO head byte, 0x00 while the FIFO is empty
//   empty      FIFO holds no bytes (registered)
//   full       FIFO holds 2**DEPTH_LOG2 bytes (registered)
//   overrun    sticky: a good byte was dropped because the FIFO was full
//   frame_err  sticky: a stop bit was sampled low
//   err_clr    clear both sticky flags (a same-cycle set wins)
//   state_dbg  current receiver state (IDLE=0 START=1 DATA=2 STOP=3 BREAK=4)
//
// Handshake: rd_en is a one-cycle pop request qualified internally by !empty;
// a pop and a push may share a cycle, and both take effect on the same edge.
// -----------------------------------------------------------------------------
module uart_rx_core #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rxd,
  input  logic [15:0] div,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic        empty,
  output logic        full,
  output logic        overrun,
  output logic        frame_err,
  input  logic        err_clr,
  output logic [2:0]  state_dbg
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // Synchroniser
  logic s1_q, rxd_s_q;

  // Receiver
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] div_eff;
  logic        tick;
  logic        push;
  logic        fe_set;

  // FIFO
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  overrun_q, overrun_d;
  logic                  frame_err_q, frame_err_d;
  logic                  pop;
  logic                  push_ok;
  logic                  drop;

  // Very short periods cannot place a mid-bit sample, so clamp to 3.
  assign div_eff = (div < 16'd3) ? 16'd3 : div;
  assign tick    = (cnt_q == 16'd0);

  // ---------------------------------------------------------------------------
  // Receiver next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    fe_set    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        if (!rxd_s_q) begin
          // Half a bit period lands the start-bit sample mid-bit.
          state_d = S_START;
          cnt_d   = div_eff >> 1;
        end
      end
      S_START: begin
        if (tick) begin
          if (!rxd_s_q) begin
            state_d   = S_DATA;
            cnt_d     = div_eff;
            bit_idx_d = 3'd0;
          end else begin
            state_d = S_IDLE;  // glitch shorter than half a bit
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d   = {rxd_s_q, shift_q[7:1]};  // LSB arrives first
          cnt_d     = div_eff;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (rxd_s_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            fe_set  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_BREAK: begin
        // A line held low must go high before another start is accepted.
        cnt_d = 16'd0;
        if (rxd_s_q) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO and sticky flag next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pop     = rd_en && !empty_q;
    // A pop in the same cycle frees the slot the push needs.
    push_ok = push && (!full_q || pop);
    drop    = push && full_q && !pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;

    empty_d = (count_d == '0);
    full_d  = (count_d == FULL_CNT);

    overrun_d = overrun_q;
    if (err_clr) overrun_d = 1'b0;
    if (drop)    overrun_d = 1'b1;

    frame_err_d = frame_err_q;
    if (err_clr) frame_err_d = 1'b0;
    if (fe_set)  frame_err_d = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q        <= 1'b1;
      rxd_s_q     <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      s1_q        <= rxd;
      rxd_s_q     <= s1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Storage needs no reset: an entry is only visible once it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_d;
  end

  assign rd_data   = empty_q ? 8'h00 : mem_q[rd_ptr_q];
  assign empty     = empty_q;
  assign full      = full_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
//   Directed bench for uart_rx_core: a table of single frames at several
//   divisors, plus hand-written sequences for exact latency, FIFO full and
//   overrun, pop-while-full, start glitch, break, and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

  logic        clk;
  logic        reset;
  logic        rxd;
  logic [15:0] div;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        empty;
  logic        full;
  logic        overrun;
  logic        frame_err;
  logic        err_clr;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic [15:0] div;
    int          bitlen;
    logic [7:0]  data;
  } vec_t;

  vec_t vecs[6];

  uart_rx_core #(.DEPTH_LOG2(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .div       (div),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .overrun   (overrun),
    .frame_err (frame_err),
    .err_clr   (err_clr),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one 8N1 frame; cycle 0 is the first start-bit cycle. rd_en is
  // asserted during cycle rd_cycle of the frame (negative for none).
  task automatic send_frame(input logic [7:0] data, input int bitlen, input int rd_cycle);
    logic [9:0] frame;
    frame = {1'b1, data, 1'b0};
    for (int c = 0; c < 10 * bitlen; c++) begin
      rxd   = frame[c / bitlen];
      rd_en = (c == rd_cycle);
      @(posedge clk);
      #1;
    end
    rxd   = 1'b1;
    rd_en = 1'b0;
  endtask

  // Scoreboard pop: head must match the expected queue, then pop it.
  task automatic pop_check(input string name);
    logic [7:0] exp;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: expected queue empty, nothing to compare", name);
    end else begin
      exp = exp_q.pop_front();
      @(negedge clk);
      check({name, "_empty"}, {31'd0, empty}, 32'd0);
      check({name, "_data"}, {24'd0, rd_data}, {24'd0, exp});
      rd_en = 1'b1;
      @(posedge clk);
      #1;
      rd_en = 1'b0;
    end
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{div: 16'd15, bitlen: 16, data: 8'hC3};
    vecs[1] = '{div: 16'd0,  bitlen: 4,  data: 8'h81};
    vecs[2] = '{div: 16'd2,  bitlen: 4,  data: 8'h00};
    vecs[3] = '{div: 16'd3,  bitlen: 4,  data: 8'hFF};
    vecs[4] = '{div: 16'd7,  bitlen: 8,  data: 8'h3C};
    vecs[5] = '{div: 16'd20, bitlen: 21, data: 8'h5A};

    reset   = 1'b1;
    rxd     = 1'b1;
    div     = 16'd15;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(5);

    // Reset state
    @(negedge clk);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_rd_data", {24'd0, rd_data}, 32'h00);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, 32'd0);
    tick(1);

    // Exact latency at D=15: empty low at cycle 154 -> 1, cycle 155 -> 0.
    fork
      send_frame(8'hA5, 16, -1);
      begin
        repeat (154) @(posedge clk);
        @(negedge clk);
        check("t1_empty_c154", {31'd0, empty}, 32'd1);
        @(negedge clk);
        check("t1_empty_c155", {31'd0, empty}, 32'd0);
      end
    join
    exp_q.push_back(8'hA5);
    tick(8);
    pop_check("t1_pop");
    @(negedge clk);
    check("t1_empty_after", {31'd0, empty}, 32'd1);
    check("t1_rd_data_after", {24'd0, rd_data}, 32'h00);
    tick(1);

    // Table of single frames at several divisors
    for (int i = 0; i < 6; i++) begin
      div = vecs[i].div;
      tick(4);
      send_frame(vecs[i].data, vecs[i].bitlen, -1);
      exp_q.push_back(vecs[i].data);
      tick(2 * vecs[i].bitlen);
      @(negedge clk);
      check($sformatf("vec%0d_frame_err", i), {31'd0, frame_err}, 32'd0);
      pop_check($sformatf("vec%0d_pop", i));
      @(negedge clk);
      check($sformatf("vec%0d_empty_after", i), {31'd0, empty}, 32'd1);
      tick(1);
    end

    // Five back-to-back frames without reads: full after 4, overrun after 5.
    div = 16'd15;
    tick(4);
    for (int b = 1; b <= 4; b++) begin
      send_frame(b[7:0], 16, -1);
      exp_q.push_back(b[7:0]);
    end
    @(negedge clk);
    check("t2_full_after4", {31'd0, full}, 32'd1);
    check("t2_overrun_after4", {31'd0, overrun}, 32'd0);
    tick(1);
    send_frame(8'h05, 16, -1);
    tick(4);
    @(negedge clk);
    check("t2_overrun_after5", {31'd0, overrun}, 32'd1);
    check("t2_full_after5", {31'd0, full}, 32'd1);
    tick(1);
    pop_check("t2_pop1");
    @(negedge clk);
    check("t2_full_after_pop", {31'd0, full}, 32'd0);
    tick(1);
    pop_check("t2_pop2");
    pop_check("t2_pop3");
    pop_check("t2_pop4");
    @(negedge clk);
    check("t2_empty_end", {31'd0, empty}, 32'd1);
    tick(1);
    pulse_err_clr();
    @(negedge clk);
    check("t2_overrun_cleared", {31'd0, overrun}, 32'd0);
    tick(1);

    // FIFO full, pop in the exact cycle the 5th stop bit is accepted (154).
    for (int b = 1; b <= 4; b++) begin
      send_frame(b[7:0], 16, -1);
      exp_q.push_back(b[7:0]);
    end
    send_frame(8'h05, 16, 154);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h05);
    tick(4);
    @(negedge clk);
    check("t3_overrun", {31'd0, overrun}, 32'd0);
    check("t3_full", {31'd0, full}, 32'd1);
    tick(1);
    pop_check("t3_pop1");
    pop_check("t3_pop2");
    pop_check("t3_pop3");
    pop_check("t3_pop4");
    @(negedge clk);
    check("t3_empty_end", {31'd0, empty}, 32'd1);
    tick(1);

    // Start glitch of 3 cycles: rejected at the start sample.
    rxd = 1'b0;
    tick(3);
    rxd = 1'b1;
    tick(40);
    @(negedge clk);
    check("t4_empty", {31'd0, empty}, 32'd1);
    check("t4_frame_err", {31'd0, frame_err}, 32'd0);
    check("t4_overrun", {31'd0, overrun}, 32'd0);
    check("t4_state_idle", {29'd0, state_dbg}, 32'd0);
    tick(1);

    // Break: line low for 12 bit times.
    rxd = 1'b0;
    tick(12 * 16);
    @(negedge clk);
    check("t5_state_break", {29'd0, state_dbg}, 32'd4);
    tick(1);
    rxd = 1'b1;
    tick(48);
    @(negedge clk);
    check("t5_frame_err", {31'd0, frame_err}, 32'd1);
    check("t5_empty", {31'd0, empty}, 32'd1);
    check("t5_state_idle", {29'd0, state_dbg}, 32'd0);
    tick(1);
    send_frame(8'h3C, 16, -1);
    exp_q.push_back(8'h3C);
    tick(16);
    pop_check("t5_pop");
    pulse_err_clr();
    @(negedge clk);
    check("t5_frame_err_cleared", {31'd0, frame_err}, 32'd0);
    check("t5_empty_end", {31'd0, empty}, 32'd1);
    tick(1);

    // Reset mid-DATA with two bytes buffered and frame_err set.
    send_frame(8'h11, 16, -1);
    send_frame(8'h22, 16, -1);
    rxd = 1'b0;
    tick(12 * 16);
    rxd = 1'b1;
    tick(48);
    @(negedge clk);
    check("t6_pre_empty", {31'd0, empty}, 32'd0);
    check("t6_pre_frame_err", {31'd0, frame_err}, 32'd1);
    tick(1);
    rxd = 1'b0;             // start bit of 0x55
    tick(16);
    rxd = 1'b1; tick(16);   // bit0
    rxd = 1'b0; tick(16);   // bit1
    rxd = 1'b1; tick(8);    // mid bit2
    check("t6_state_data", {29'd0, state_dbg}, 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_empty", {31'd0, empty}, 32'd1);
    check("t6_rst_full", {31'd0, full}, 32'd0);
    check("t6_rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("t6_rst_overrun", {31'd0, overrun}, 32'd0);
    check("t6_rst_rd_data", {24'd0, rd_data}, 32'h00);
    check("t6_rst_state", {29'd0, state_dbg}, 32'd0);
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    tick(20);
    send_frame(8'h7E, 16, -1);
    exp_q.push_back(8'h7E);
    tick(16);
    pop_check("t6_pop");
    @(negedge clk);
    check("t6_only_one_byte", {31'd0, empty}, 32'd1);
    check("t6_frame_err_end", {31'd0, frame_err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Serial receive engine feeding the memory-mapped UART register slave.
- Synchronises the rxd pin and deserialises 8N1 frames using the slave's 16-bit divisor {div1,div0}.
- Buffers received bytes in a small first-word-fall-through FIFO.
- The register slave pops it through the data register (read data = rd_data, status bit0 = empty).

Parameters:
- DEPTH_LOG2, 2, log2 of FIFO depth (default 4 entries); legal 1..4.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rxd  input  1  asynchronous serial input, idle high
- div  input  16  bit period minus one, in clk cycles; values below 3 are treated as 3
- rd_en  input  1  pop FIFO head this cycle (from register slave data-register read)
- rd_data  output  8  FIFO head byte; combinational from storage; 0x00 when empty
- empty  output  1  FIFO holds no bytes
- full  output  1  FIFO holds 2**DEPTH_LOG2 bytes
- overrun  output  1  sticky: valid byte dropped because FIFO was full
- frame_err  output  1  sticky: stop bit sampled low
- err_clr  input  1  clear both sticky flags

Behaviour:
- Reset (async, any time, including mid-frame):
  - Synchroniser flops = 1.
  - State = IDLE; bit counter and baud counter = 0.
  - FIFO pointers = 0: empty=1, full=0, rd_data=0x00.
  - overrun=0, frame_err=0.
  - After reset release, no false start is detected.
- Synchroniser: two flops, rxd -> s1 -> rxd_s. Added latency is 2 cycles.
- Let D = max(div,3). The baud counter cnt loads a value and decrements once per cycle. A "tick" is a cycle in which cnt==0.
- IDLE: if rxd_s==0, go to START and load cnt = D>>1.
- START on tick: sample rxd_s.
  - If 0: go to DATA, cnt=D, bit_idx=0.
  - If 1 (glitch): return to IDLE; nothing is pushed and no flag is set.
- DATA on tick: shift rxd_s into the shift register, LSB first; cnt=D; bit_idx++.
  - After the 8th sample (bit_idx wraps 7->0): go to STOP, cnt=D.
- STOP on tick: sample rxd_s.
  - If 1: push the shift register into the FIFO, then go to IDLE.
  - If 0: set frame_err, discard the byte, go to BREAK.
- BREAK: wait for rxd_s==1, then go to IDLE. This prevents a line held low from being read as back-to-back 0x00 frames.
- Push with FIFO full:
  - If rd_en is also asserted that cycle, pop and push both occur; occupancy is unchanged and there is no overrun.
  - Otherwise the byte is dropped and overrun is set.
- rd_en with FIFO empty is ignored. If a push and a pop coincide while empty, the pop is ignored and the byte is stored.
- Push and pop update pointers and occupancy on the same clk edge. empty and full are registered; they change in the cycle after the edge.
- Pointers wrap modulo the depth. The occupancy counter is DEPTH_LOG2+1 bits wide.
- err_clr clears both sticky flags. If a set event occurs in the same cycle as err_clr, the set wins.
- div changes mid-frame take effect at the next counter reload.
- Timing at D=15, measured from the cycle rxd first reads low (cycle 0):
  - rxd_s low at cycle 2; START entered at cycle 3.
  - Start sample at cycle 10; data bit k sampled at cycle 26+16k; stop sample at cycle 154.
  - empty=0 from cycle 155.

Test Plan:
- div=15, send 0xA5 (8N1, 16 clk/bit) -> empty falls exactly at cycle 155 after the start edge; rd_data=0xA5. Pulse rd_en once -> empty=1, rd_data=0x00.
- div=15, send 0x01,0x02,0x03,0x04,0x05 back-to-back with no reads -> full=1 after the 4th byte; overrun=1 after the 5th; pops return 01,02,03,04; err_clr -> overrun=0.
- FIFO full; assert rd_en in the exact cycle the 5th byte's stop bit is accepted -> overrun stays 0; pops return 02,03,04,05.
- div=15, 3-cycle low glitch on idle rxd -> START sample reads 1, back to IDLE; empty stays 1 and both flags stay 0.
- div=15, hold rxd low for 12 bit times, then release -> frame_err=1, nothing pushed; a following valid 0x3C is received correctly.
- Assert reset mid-DATA of frame 0x55 while FIFO holds 2 bytes -> empty=1, flags 0 immediately. Line idle then a valid 0x7E -> only 0x7E received.
- div=0 -> behaves as D=3 (4 clk/bit); 0x81 sent at 4 clk/bit is received correctly.
